clk_div_multi: RTL and testbench

//   Multi-channel programmable clock divider; successor to the fixed single-output divider.
//   CH independent channels, each producing a square clock-enable clk_out and a one-cycle tick.

---
 rtl/clk_div_multi.sv | 162 ++++++++++++++++
 tb/tb_clk_div_multi.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_multi
//  Purpose  : Multi-channel programmable clock divider. Each of CH channels
//             produces a registered square clock-enable (clk_out_o) and a
//             one-cycle tick (tick_o) once per period of P clk cycles.
//             P can be rewritten at run time. A new value is held pending and
//             applied only when the current period ends, so clk_out_o never
//             shows a runt pulse. sync_all_i restarts all enabled channels
//             in phase.
//  Ports    : clk          system clock (posedge)
//             rst_n        asynchronous active-low reset
//             en_i         [CH]  per-channel run enable
//             div_wr_i           one-cycle divisor write strobe
//             div_sel_i    [SW]  channel index for the write
//             div_val_i    [CW]  new period P (clk cycles per output cycle)
//             sync_all_i         restart every enabled channel at phase 0
//             clk_out_o    [CH]  divided square output (low phase first)
//             tick_o       [CH]  one-cycle pulse after each period wrap
//             pend_o       [CH]  written divisor waiting for a wrap
//             div_err_o          one-cycle pulse: previous write rejected
//  Revision : 1.0  initial release
// ============================================================================
module clk_div_multi #(
  parameter int CH      = 4,
  parameter int CW      = 32,
  parameter int DEF_DIV = 100_000_000,
  // Derived from CH; leave at its default.
  parameter int SW      = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] en_i,
  input  logic          div_wr_i,
  input  logic [SW-1:0] div_sel_i,
  input  logic [CW-1:0] div_val_i,
  input  logic          sync_all_i,
  output logic [CH-1:0] clk_out_o,
  output logic [CH-1:0] tick_o,
  output logic [CH-1:0] pend_o,
  output logic          div_err_o
);

  localparam logic [CW-1:0] DEF_P = CW'(DEF_DIV);
  localparam logic [CW-1:0] MIN_P = CW'(2);

  // --------------------------------------------------------------------------
  // Write qualification, shared by all channels
  // --------------------------------------------------------------------------
  logic sel_ok;
  logic wr_ok;
  logic div_err_q;
  logic div_err_d;

  // When CH fills the whole select range every index is legal; comparing
  // would be a constant expression, so it is only built when needed.
  if (CH == (1 << SW)) begin : g_sel_full
    assign sel_ok = 1'b1;
  end else begin : g_sel_part
    localparam logic [SW:0] CH_V = (SW + 1)'(CH);
    assign sel_ok = ({1'b0, div_sel_i} < CH_V);
  end

  assign wr_ok     = div_wr_i && sel_ok && (div_val_i >= MIN_P);
  assign div_err_d = div_wr_i && !wr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_err_q <= 1'b0;
    end else begin
      div_err_q <= div_err_d;
    end
  end

  assign div_err_o = div_err_q;

  // --------------------------------------------------------------------------
  // Per-channel divider
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic [CW-1:0] cnt_q, cnt_d;    // phase within current period, 0..P-1
    logic [CW-1:0] per_q, per_d;    // active period P
    logic [CW-1:0] nxt_q, nxt_d;    // pending period, valid when pend_q
    logic          pend_q, pend_d;
    logic          clk_q, clk_d;
    logic          tick_q, tick_d;
    logic [CW-1:0] low_len;
    logic [CW-1:0] cnt_inc;
    logic          wrap;
    logic          hit;
    logic          apply;

    // Odd periods give the extra cycle to the low phase.
    assign low_len = per_q - (per_q >> 1);
    assign cnt_inc = cnt_q + CW'(1);
    assign wrap    = (cnt_q == (per_q - CW'(1)));
    assign hit     = wr_ok && (div_sel_i == SW'(gi));

    always_comb begin
      cnt_d  = cnt_q;
      per_d  = per_q;
      nxt_d  = nxt_q;
      pend_d = pend_q;
      clk_d  = 1'b0;
      tick_d = 1'b0;
      apply  = 1'b0;

      // Priority: disable > sync > wrap > count. Every restart point is also
      // a period boundary, so a pending divisor may be applied there.
      if (!en_i[gi]) begin
        cnt_d = '0;
        apply = 1'b1;
      end else if (sync_all_i) begin
        cnt_d = '0;
        apply = 1'b1;
      end else if (wrap) begin
        cnt_d  = '0;
        apply  = 1'b1;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_inc;
        // Output follows the next count so it changes on the same edge.
        clk_d = (cnt_inc >= low_len);
      end

      // Apply uses the value pending before this edge; a write landing on
      // the same edge becomes the next pending value.
      if (apply && pend_q) begin
        per_d  = nxt_q;
        pend_d = 1'b0;
      end
      if (hit) begin
        nxt_d  = div_val_i;
        pend_d = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        per_q  <= DEF_P;
        nxt_q  <= DEF_P;
        pend_q <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        per_q  <= per_d;
        nxt_q  <= nxt_d;
        pend_q <= pend_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
      end
    end

    assign clk_out_o[gi] = clk_q;
    assign tick_o[gi]    = tick_q;
    assign pend_o[gi]    = pend_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_div_multi
//  Purpose  : Self-checking bench for clk_div_multi (CH=6, CW=16, DEF_DIV=10).
//             Directed scenarios followed by randomized writes, enables and
//             sync strobes, compared every cycle against a cycle-count model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_clk_div_multi;

  localparam int CH  = 6;
  localparam int CW  = 16;
  localparam int DEF = 10;
  localparam int SW  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] en;
  logic          div_wr;
  logic [SW-1:0] div_sel;
  logic [CW-1:0] div_val;
  logic          sync_all;
  logic [CH-1:0] clk_out;
  logic [CH-1:0] tick;
  logic [CH-1:0] pend;
  logic          div_err;

  clk_div_multi #(
    .CH     (CH),
    .CW     (CW),
    .DEF_DIV(DEF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (en),
    .div_wr_i  (div_wr),
    .div_sel_i (div_sel),
    .div_val_i (div_val),
    .sync_all_i(sync_all),
    .clk_out_o (clk_out),
    .tick_o    (tick),
    .pend_o    (pend),
    .div_err_o (div_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: elapsed cycles since the current period started,
  // active period, and the pending divisor.
  int            m_age  [CH];
  int            m_per  [CH];
  int            m_nxt  [CH];
  bit            m_pend [CH];
  logic [CH-1:0] e_clk;
  logic [CH-1:0] e_tick;
  logic [CH-1:0] e_pend;
  logic          e_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_age[i]  = 0;
      m_per[i]  = DEF;
      m_nxt[i]  = DEF;
      m_pend[i] = 1'b0;
    end
    e_clk  = '0;
    e_tick = '0;
    e_pend = '0;
    e_err  = 1'b0;
  endtask

  // One clock edge of the specified behaviour, from the inputs held across it.
  task automatic model_edge();
    bit ok;
    bit restart;
    ok = div_wr && (int'(div_val) >= 2) && (int'(div_sel) < CH);
    for (int i = 0; i < CH; i++) begin
      restart   = 1'b0;
      e_tick[i] = 1'b0;
      if (!en[i] || sync_all) begin
        m_age[i] = 0;
        restart  = 1'b1;
      end else if (m_age[i] + 1 == m_per[i]) begin
        m_age[i]  = 0;
        restart   = 1'b1;
        e_tick[i] = 1'b1;
      end else begin
        m_age[i] = m_age[i] + 1;
      end
      if (restart && m_pend[i]) begin
        m_per[i]  = m_nxt[i];
        m_pend[i] = 1'b0;
      end
      if (ok && int'(div_sel) == i) begin
        m_nxt[i]  = int'(div_val);
        m_pend[i] = 1'b1;
      end
      // High for the last floor(P/2) cycles of each period.
      e_clk[i]  = (m_age[i] >= m_per[i] - m_per[i] / 2);
      e_pend[i] = m_pend[i];
    end
    e_err = div_wr && !ok;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("clk_out", 32'(clk_out), 32'(e_clk));
    chk("tick",    32'(tick),    32'(e_tick));
    chk("pend",    32'(pend),    32'(e_pend));
    chk("div_err", 32'(div_err), 32'(e_err));
    div_wr   = 1'b0;
    sync_all = 1'b0;
  endtask

  task automatic write(input int sel, input int val);
    div_wr  = 1'b1;
    div_sel = SW'(sel);
    div_val = CW'(val);
  endtask

  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_tick",    32'(tick),    32'd0);
    chk("rst_pend",    32'(pend),    32'd0);
    chk("rst_div_err", 32'(div_err), 32'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int guard;
    rst_n    = 1'b0;
    en       = '0;
    div_wr   = 1'b0;
    div_sel  = '0;
    div_val  = '0;
    sync_all = 1'b0;
    model_reset();
    #20;
    chk("init_clk_out", 32'(clk_out), 32'd0);
    chk("init_tick",    32'(tick),    32'd0);
    chk("init_pend",    32'(pend),    32'd0);
    chk("init_div_err", 32'(div_err), 32'd0);
    #2;
    rst_n = 1'b1;

    // Default period on channel 0.
    en[0] = 1'b1;
    repeat (25) step();

    // New divisor on a disabled channel, then enable.
    write(2, 7);
    step();
    chk("pend2_set", 32'(pend[2]), 32'd1);
    step();
    en[2] = 1'b1;
    repeat (20) step();

    // Mid-period rewrite on a running channel.
    en[1] = 1'b1;
    repeat (3) step();
    write(1, 4);
    step();
    repeat (25) step();

    // Rejected writes.
    write(0, 1);
    step();
    write(3, 9);
    div_sel = 3'd6;
    step();
    write(7, 5);
    step();
    write(4, 0);
    step();
    step();

    // Out-of-phase channels brought into alignment.
    en[3] = 1'b1;
    repeat (4) step();
    sync_all = 1'b1;
    step();
    repeat (12) step();

    // Sync landing on a wrap edge of channel 0.
    guard = 0;
    while (m_age[0] + 1 != m_per[0] && guard < 40) begin
      step();
      guard++;
    end
    chk("wrap_found", 32'(guard < 40), 32'd1);
    sync_all = 1'b1;
    step();
    repeat (5) step();

    // Asynchronous reset during a high phase of channel 0.
    guard = 0;
    while (!e_clk[0] && guard < 40) begin
      step();
      guard++;
    end
    chk("high_found", 32'(guard < 40), 32'd1);
    mid_reset();
    repeat (15) step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) en[$urandom_range(0, CH - 1)] ^= 1'b1;
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 7) == 0) write($urandom_range(0, 7), $urandom_range(0, 1));
        else write($urandom_range(0, 7), $urandom_range(2, 12));
      end
      if ($urandom_range(0, 49) == 0) sync_all = 1'b1;
      step();
      if (c == 1500) mid_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
